// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and bit-timing derivations.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } uart_state_e;

    function automatic int unsigned cycles_per_bit(input int unsigned clk_hz,
                                                   input int unsigned bit_rate);
        return clk_hz / bit_rate;
    endfunction

    function automatic int unsigned half_bit_cycles(input int unsigned clk_hz,
                                                    input int unsigned bit_rate);
        return cycles_per_bit(clk_hz, bit_rate) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling of an LSB-first frame with frame-error and break reporting.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned BIT_RATE     = 9600,
    parameter int unsigned CLK_HZ       = 50000000,
    parameter int unsigned PAYLOAD_BITS = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data,
    output logic                    uart_rx_valid,
    output logic                    uart_rx_frame_err,
    output logic                    uart_rx_break
);

    localparam int unsigned CPB   = cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam int unsigned HALF  = half_bit_cycles(CLK_HZ, BIT_RATE);
    localparam int unsigned CNT_W = $clog2(CPB + 1);
    localparam int unsigned BIT_W = $clog2(PAYLOAD_BITS + 1);

    logic rxd_p0;
    logic rxd_p1;

    uart_state_e             state, state_n;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic [BIT_W-1:0]        bit_cnt, bit_cnt_n;
    logic [PAYLOAD_BITS-1:0] shift, shift_n;
    logic [PAYLOAD_BITS-1:0] data_n;
    logic                    valid_n, ferr_n, brk_n;

    uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (uart_rxd),
        .q     (rxd_p0)
    );

    // Stage boundary: synchronised line -> delayed copy for falling-edge detection
    always_ff @(posedge clk) begin
        if (reset) rxd_p1 <= 1'b1;
        else       rxd_p1 <= rxd_p0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            cnt               <= '0;
            bit_cnt           <= '0;
            shift             <= '0;
            uart_rx_data      <= '0;
            uart_rx_valid     <= 1'b0;
            uart_rx_frame_err <= 1'b0;
            uart_rx_break     <= 1'b0;
        end else begin
            state             <= state_n;
            cnt               <= cnt_n;
            bit_cnt           <= bit_cnt_n;
            shift             <= shift_n;
            uart_rx_data      <= data_n;
            uart_rx_valid     <= valid_n;
            uart_rx_frame_err <= ferr_n;
            uart_rx_break     <= brk_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 1'b1;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        data_n    = uart_rx_data;
        valid_n   = 1'b0;
        ferr_n    = 1'b0;
        brk_n     = 1'b0;
        case (state)
            IDLE: begin
                cnt_n     = '0;
                bit_cnt_n = '0;
                if (uart_rx_en && rxd_p1 && !rxd_p0) state_n = START;
            end
            START: begin
                // Re-check the start bit at its centre to reject short glitches
                if (cnt == CNT_W'(HALF - 1)) begin
                    cnt_n   = '0;
                    state_n = rxd_p0 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == CNT_W'(CPB - 1)) begin
                    cnt_n     = '0;
                    shift_n   = {rxd_p0, shift[PAYLOAD_BITS-1:1]};
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == BIT_W'(PAYLOAD_BITS - 1)) state_n = STOP;
                end
            end
            STOP: begin
                if (cnt == CNT_W'(CPB - 1)) begin
                    cnt_n = '0;
                    if (rxd_p0) begin
                        data_n  = shift;
                        valid_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        // A low stop after an all-zero payload means the line is held in break
                        ferr_n  = 1'b1;
                        brk_n   = (shift == '0);
                        state_n = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_n = '0;
                if (rxd_p0) state_n = IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

endmodule
